pos_pid_mc: RTL and testbench

//   Multi-channel, time-multiplexed position PID controller for the galvo loop.
//   One shared multiplier serves CH axes sequentially, once per ADC sample.

---
 rtl/pos_pid_mc.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_pos_pid_mc.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pos_pid_mc.sv
`default_nettype none
// ============================================================================
//  Module   : pos_pid_mc
//  Purpose  : Multi-channel, time-multiplexed position PID controller for the
//             galvo loop. One shared multiplier serves CH axes in turn, once
//             per ADC sample set. Gains and limits are shared by all axes.
//             The integrator and previous error are kept per channel.
//  Ports    : clk_pid, sys_rstn        - clock, async active-low reset
//             kp, ki, kd               - unsigned shared gains (FRAC frac bits)
//             dac_limit                - unsigned output magnitude limit
//             pid_i_saturation         - unsigned integrator magnitude limit
//             pos_target, pos_adc      - packed unsigned per-channel positions
//             adc_valid / adc_ready    - sample handshake (ready in IDLE only)
//             pid_clr                  - clear state, abort computation
//             pos_dac / dac_valid      - packed signed results, 1-cycle strobe
//             overrun                  - 1-cycle pulse: sample dropped (busy)
//  Revision : 1.0  initial release
// ============================================================================
module pos_pid_mc #(
  parameter int CH   = 2,
  parameter int DW   = 16,
  parameter int KW   = 16,
  parameter int IW   = 24,
  parameter int FRAC = 10
) (
  input  logic               clk_pid,
  input  logic               sys_rstn,
  input  logic [KW-1:0]      kp,
  input  logic [KW-1:0]      ki,
  input  logic [KW-1:0]      kd,
  input  logic [DW-1:0]      dac_limit,
  input  logic [IW-1:0]      pid_i_saturation,
  input  logic [CH*DW-1:0]   pos_target,
  input  logic [CH*DW-1:0]   pos_adc,
  input  logic               adc_valid,
  input  logic               pid_clr,
  output logic               adc_ready,
  output logic [CH*DW-1:0]   pos_dac,
  output logic               dac_valid,
  output logic               overrun
);

  // Internal widths: error, derivative, integrator sum, product, accumulator.
  localparam int EW  = DW + 1;
  localparam int DEW = DW + 2;
  localparam int ISW = IW + 1;
  localparam int PW  = KW + 1 + IW;
  localparam int AW  = KW + IW + 4;
  localparam int NW  = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [IW-1:0] C_IMAX  = {1'b0, {(IW-1){1'b1}}};
  localparam logic [DW-1:0] C_DMAX  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [NW-1:0] C_NLAST = NW'(CH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ERR  = 3'd1,
    S_MP   = 3'd2,
    S_MI   = 3'd3,
    S_MD   = 3'd4,
    S_OUT  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [NW-1:0]        n_q, n_d;

  // Operands captured at accept so the run is immune to input changes.
  logic [DW-1:0]        tgt_q   [CH];
  logic [DW-1:0]        adc_q   [CH];
  logic [KW-1:0]        kp_q, ki_q, kd_q;
  logic [DW-1:0]        dlim_q;
  logic [IW-1:0]        isat_q;

  // Per-channel loop state.
  logic signed [IW-1:0] integ_q [CH];
  logic signed [EW-1:0] eprev_q [CH];

  // Working registers for the channel being processed.
  logic signed [EW-1:0]  e_q;
  logic signed [DEW-1:0] de_q;
  logic signed [IW-1:0]  inew_q;
  logic signed [AW-1:0]  acc_q;

  // Results are collected in the shadow and published together.
  logic [DW-1:0]        shadow_q [CH];
  logic [DW-1:0]        dac_q    [CH];
  logic                 dac_valid_q;
  logic                 overrun_q;

  // --------------------------------------------------------------------------
  // Error, derivative and saturated integrator for channel n_q
  // --------------------------------------------------------------------------
  logic signed [EW-1:0]  w_e;
  logic signed [DEW-1:0] w_de;
  logic signed [ISW-1:0] w_isum;
  logic [IW-1:0]         w_ilim_u;
  logic signed [ISW-1:0] w_ilim;
  logic signed [ISW-1:0] w_ilim_n;
  logic signed [IW-1:0]  w_integ;

  always_comb begin
    w_e      = $signed({1'b0, tgt_q[n_q]}) - $signed({1'b0, adc_q[n_q]});
    w_de     = DEW'(w_e) - DEW'(eprev_q[n_q]);
    w_isum   = ISW'(integ_q[n_q]) + ISW'(w_e);
    // The limit cannot exceed what the signed integrator register can hold.
    w_ilim_u = (isat_q > C_IMAX) ? C_IMAX : isat_q;
    w_ilim   = $signed({1'b0, w_ilim_u});
    w_ilim_n = -w_ilim;
    if (w_isum > w_ilim) begin
      w_integ = w_ilim[IW-1:0];
    end else if (w_isum < w_ilim_n) begin
      w_integ = w_ilim_n[IW-1:0];
    end else begin
      w_integ = w_isum[IW-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Shared multiplier: gain (zero-extended) times the state's operand
  // --------------------------------------------------------------------------
  logic [KW-1:0]         w_gain;
  logic signed [IW-1:0]  w_op;
  logic signed [PW-1:0]  w_prod;

  always_comb begin
    w_gain = kp_q;
    w_op   = IW'(e_q);
    case (state_q)
      S_MI: begin
        w_gain = ki_q;
        w_op   = inew_q;
      end
      S_MD: begin
        w_gain = kd_q;
        w_op   = IW'(de_q);
      end
      default: ;
    endcase
  end

  assign w_prod = PW'($signed({1'b0, w_gain})) * PW'(w_op);

  // --------------------------------------------------------------------------
  // Output scaling and symmetric clamp
  // --------------------------------------------------------------------------
  logic signed [AW-1:0] w_sh;
  logic [DW-1:0]        w_dlim_u;
  logic signed [AW-1:0] w_dlim;
  logic signed [AW-1:0] w_dlim_n;
  logic [DW-1:0]        w_y;

  always_comb begin
    w_sh     = acc_q >>> FRAC;
    // Keep the limit inside the positive range of a signed DW-bit word.
    w_dlim_u = (dlim_q > C_DMAX) ? C_DMAX : dlim_q;
    w_dlim   = $signed(AW'(w_dlim_u));
    w_dlim_n = -w_dlim;
    if (w_sh > w_dlim) begin
      w_y = w_dlim[DW-1:0];
    end else if (w_sh < w_dlim_n) begin
      w_y = w_dlim_n[DW-1:0];
    end else begin
      w_y = w_sh[DW-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_pid or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q <= S_IDLE;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    if (pid_clr) begin
      state_d = S_IDLE;
      n_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (adc_valid) begin
            state_d = S_ERR;
            n_d     = '0;
          end
        end
        S_ERR:  state_d = S_MP;
        S_MP:   state_d = S_MI;
        S_MI:   state_d = S_MD;
        S_MD:   state_d = S_OUT;
        S_OUT: begin
          if (n_q == C_NLAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
            n_d     = n_q + 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_pid or negedge sys_rstn) begin
    if (!sys_rstn) begin
      for (int i = 0; i < CH; i++) begin
        tgt_q[i]    <= '0;
        adc_q[i]    <= '0;
        integ_q[i]  <= '0;
        eprev_q[i]  <= '0;
        shadow_q[i] <= '0;
        dac_q[i]    <= '0;
      end
      kp_q        <= '0;
      ki_q        <= '0;
      kd_q        <= '0;
      dlim_q      <= '0;
      isat_q      <= '0;
      e_q         <= '0;
      de_q        <= '0;
      inew_q      <= '0;
      acc_q       <= '0;
      dac_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      dac_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (pid_clr) begin
        // Abort: loop state cleared, published outputs left untouched.
        for (int i = 0; i < CH; i++) begin
          integ_q[i] <= '0;
          eprev_q[i] <= '0;
        end
      end else begin
        if (adc_valid && (state_q != S_IDLE)) begin
          overrun_q <= 1'b1;
        end
        case (state_q)
          S_IDLE: begin
            if (adc_valid) begin
              for (int i = 0; i < CH; i++) begin
                tgt_q[i] <= pos_target[i*DW +: DW];
                adc_q[i] <= pos_adc[i*DW +: DW];
              end
              kp_q   <= kp;
              ki_q   <= ki;
              kd_q   <= kd;
              dlim_q <= dac_limit;
              isat_q <= pid_i_saturation;
            end
          end
          S_ERR: begin
            e_q    <= w_e;
            de_q   <= w_de;
            inew_q <= w_integ;
          end
          S_MP: acc_q <= AW'(w_prod);
          S_MI, S_MD: acc_q <= acc_q + AW'(w_prod);
          S_OUT: begin
            // Loop state is committed only once the channel's result exists.
            shadow_q[n_q] <= w_y;
            integ_q[n_q]  <= inew_q;
            eprev_q[n_q]  <= e_q;
          end
          S_DONE: begin
            for (int i = 0; i < CH; i++) begin
              dac_q[i] <= shadow_q[i];
            end
            dac_valid_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < CH; g++) begin : g_pack
    assign pos_dac[g*DW +: DW] = dac_q[g];
  end

  assign adc_ready = (state_q == S_IDLE);
  assign dac_valid = dac_valid_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_pos_pid_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pos_pid_mc
//  Purpose  : Self-checking bench for pos_pid_mc (CH=2). Directed scenarios
//             plus randomized sample sets compared against an arithmetic
//             reference model of the controller.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pos_pid_mc;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] kp = '0, ki = '0, kd = '0;
  logic [15:0] dlim = 16'd5000;
  logic [23:0] isat = 24'd5000;
  logic [15:0] tgt [2];
  logic [15:0] adc [2];
  logic        adc_valid = 1'b0;
  logic        pid_clr = 1'b0;
  logic [31:0] pos_target, pos_adc;
  logic        adc_ready, dac_valid, overrun;
  logic [31:0] pos_dac;

  assign pos_target = {tgt[1], tgt[0]};
  assign pos_adc    = {adc[1], adc[0]};

  pos_pid_mc #(.CH(2), .DW(16), .KW(16), .IW(24), .FRAC(10)) dut (
    .clk_pid          (clk),
    .sys_rstn         (rstn),
    .kp               (kp),
    .ki               (ki),
    .kd               (kd),
    .dac_limit        (dlim),
    .pid_i_saturation (isat),
    .pos_target       (pos_target),
    .pos_adc          (pos_adc),
    .adc_valid        (adc_valid),
    .pid_clr          (pid_clr),
    .adc_ready        (adc_ready),
    .pos_dac          (pos_dac),
    .dac_valid        (dac_valid),
    .overrun          (overrun)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  longint m_integ [2];
  longint m_eprev [2];
  longint ey [2];

  function automatic longint lmin(input longint a, input longint b);
    return (a < b) ? a : b;
  endfunction

  function automatic longint clampl(input longint v, input longint lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      m_integ[c] = 0;
      m_eprev[c] = 0;
    end
  endtask

  // One full sample: uses the values currently presented at the inputs.
  task automatic model_step();
    longint e, de, ni, acc, il, dl;
    il = lmin(longint'(isat), 64'sd8388607);
    dl = lmin(longint'(dlim), 64'sd32767);
    for (int c = 0; c < 2; c++) begin
      e   = longint'(tgt[c]) - longint'(adc[c]);
      de  = e - m_eprev[c];
      ni  = clampl(m_integ[c] + e, il);
      acc = longint'(kp) * e + longint'(ki) * ni + longint'(kd) * de;
      ey[c] = clampl(acc >>> 10, dl);
      m_integ[c] = ni;
      m_eprev[c] = e;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_pos(input int t0, input int a0, input int t1, input int a1);
    tgt[0] = 16'(t0);
    adc[0] = 16'(a0);
    tgt[1] = 16'(t1);
    adc[1] = 16'(a1);
  endtask

  task automatic set_gains(input int p, input int i, input int d);
    kp = 16'(p);
    ki = 16'(i);
    kd = 16'(d);
  endtask

  task automatic do_clr();
    @(negedge clk);
    pid_clr = 1'b1;
    @(negedge clk);
    pid_clr = 1'b0;
    model_clear();
  endtask

  // Launch one sample; lat = edges after acceptance until dac_valid (0 = none).
  task automatic run(input int ovr_at, input int clr_at, input bit scramble,
                     output int lat, output int ovr_cnt, output int ovr_cyc,
                     output logic rdy3);
    lat = 0;
    ovr_cnt = 0;
    ovr_cyc = 0;
    rdy3 = 1'bx;
    @(negedge clk);
    adc_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    adc_valid = 1'b0;
    if (scramble) begin
      tgt[0] = 16'($urandom);
      tgt[1] = 16'($urandom);
      adc[0] = 16'($urandom);
      adc[1] = 16'($urandom);
      set_gains($urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535));
      dlim = 16'($urandom);
      isat = 24'($urandom);
    end
    for (int c = 1; c <= 40; c++) begin
      if (c == ovr_at) adc_valid = 1'b1;
      if (c == clr_at) pid_clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      adc_valid = 1'b0;
      pid_clr = 1'b0;
      if (c == 3) rdy3 = adc_ready;
      if (overrun === 1'b1) begin
        ovr_cnt++;
        ovr_cyc = c;
      end
      if (dac_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  function automatic longint ch(input int n);
    logic signed [15:0] v;
    v = pos_dac[n*16 +: 16];
    return longint'(v);
  endfunction

  // Run one sample and check latency plus both channel results.
  task automatic run_chk(input string tag, input longint e0, input longint e1);
    int lat, oc, ocy;
    logic rdy3;
    model_step();
    run(0, 0, 1'b0, lat, oc, ocy, rdy3);
    chk({tag, "_lat"}, lat, 11);
    chk({tag, "_ch0"}, ch(0), e0);
    chk({tag, "_ch1"}, ch(1), e1);
    chk({tag, "_model0"}, ch(0), ey[0]);
    chk({tag, "_model1"}, ch(1), ey[1]);
  endtask

  initial begin
    int lat, oc, ocy, seen;
    logic rdy3;
    set_pos(0, 0, 0, 0);
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_dac", pos_dac, 0);
    chk("rst_dv", dac_valid, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_rdy", adc_ready, 1);
    rstn = 1'b1;
    @(negedge clk);

    // 1. P only, with latency, ready and pulse-width checks
    set_gains(1024, 0, 0);
    set_pos(10000, 9000, 0, 3000);
    model_step();
    run(0, 0, 1'b0, lat, oc, ocy, rdy3);
    chk("p_lat", lat, 11);
    chk("p_ch0", ch(0), 1000);
    chk("p_ch1", ch(1), -3000);
    chk("p_busy_rdy", rdy3, 0);
    chk("p_done_rdy", adc_ready, 1);
    @(negedge clk);
    chk("p_dv_pulse", dac_valid, 0);

    // 2. Output clamp
    set_pos(10000, 0, 0, 10000);
    run_chk("clamp", 5000, -5000);

    // 3. Integrator windup
    do_clr();
    set_gains(0, 1024, 0);
    set_pos(3000, 0, 0, 0);
    run_chk("wind1", 3000, 0);
    run_chk("wind2", 5000, 0);
    run_chk("wind3", 5000, 0);

    // 4. Derivative, first sample sees the full error
    do_clr();
    set_gains(0, 0, 1024);
    set_pos(100, 0, 0, 0);
    run_chk("der1", 100, 0);
    set_pos(300, 0, 0, 0);
    run_chk("der2", 200, 0);

    // Limits of zero
    set_gains(1024, 0, 0);
    set_pos(10000, 0, 0, 10000);
    dlim = 16'd0;
    run_chk("dlim0", 0, 0);
    dlim = 16'd5000;
    do_clr();
    set_gains(0, 1024, 0);
    set_pos(3000, 0, 0, 3000);
    isat = 24'd0;
    run_chk("isat0", 0, 0);
    isat = 24'd5000;

    // 5a. Overrun while busy; the run completes unchanged
    do_clr();
    set_pos(3000, 0, 0, 0);
    model_step();
    run(5, 0, 1'b0, lat, oc, ocy, rdy3);
    chk("ovr_count", oc, 1);
    chk("ovr_cycle", ocy, 5);
    chk("ovr_lat", lat, 11);
    chk("ovr_ch0", ch(0), 3000);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (dac_valid === 1'b1) seen++;
    end
    chk("ovr_no_extra", seen, 0);

    // 5b. Clear mid-run: no result, outputs held, integrator restarted
    set_pos(3000, 0, 0, 0);
    run(0, 4, 1'b0, lat, oc, ocy, rdy3);
    model_clear();
    chk("clr_nodv", lat, 0);
    chk("clr_hold0", ch(0), 3000);
    chk("clr_rdy", adc_ready, 1);
    run_chk("clr_next", 3000, 0);

    // Clear coincident with a sample: sample dropped, no overrun
    @(negedge clk);
    adc_valid = 1'b1;
    pid_clr = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
    pid_clr = 1'b0;
    model_clear();
    chk("clrcoin_rdy", adc_ready, 1);
    chk("clrcoin_ovr", overrun, 0);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (dac_valid === 1'b1) seen++;
    end
    chk("clrcoin_nodv", seen, 0);

    // 6. Reset mid-run, then a run identical to a fresh one
    set_gains(1024, 0, 0);
    set_pos(10000, 9000, 0, 3000);
    @(negedge clk);
    adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mrst_dac", pos_dac, 0);
    chk("mrst_rdy", adc_ready, 1);
    chk("mrst_dv", dac_valid, 0);
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
    run_chk("mrst_next", 1000, -3000);

    // Randomized sample sets; inputs are scrambled after each accept.
    for (int it = 0; it < 25; it++) begin
      if (it % 7 == 6) do_clr();
      set_gains($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095));
      set_pos($urandom_range(0, 65535), $urandom_range(0, 65535),
              $urandom_range(0, 65535), $urandom_range(0, 65535));
      dlim = 16'($urandom_range(0, 40000));
      isat = (it % 5 == 0) ? 24'($urandom) : 24'($urandom_range(0, 20000));
      model_step();
      run(0, 0, 1'b1, lat, oc, ocy, rdy3);
      chk("rnd_lat", lat, 11);
      chk("rnd_ch0", ch(0), ey[0]);
      chk("rnd_ch1", ch(1), ey[1]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
